// File: rtl/modexp_ctrl.sv
// Modular exponentiation controller: result = (base ^ exp) mod n, computed with
// right-to-left binary square-and-multiply. Products are delegated to an
// external modular multiplier through a go/done handshake.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   go, base, exp, n     start request and operands (captured when go is accepted in idle)
//   result, done, busy   final value, one-cycle completion pulse, operation-in-progress flag
//   mm_go, mm_a/b/n      request pulse and operands to the multiplier
//   mm_result, mm_done   product and completion pulse from the multiplier
module modexp_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             mm_go,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic [WIDTH-1:0] mm_result,
  input  logic             mm_done
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StMulReq,
    StMulWait,
    StSqrReq,
    StSqrWait,
    StGap,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sqr_pend_q, sqr_pend_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             mm_go_q, mm_go_d;
  logic [WIDTH-1:0] mm_a_q, mm_a_d;
  logic [WIDTH-1:0] mm_b_q, mm_b_d;
  logic [WIDTH-1:0] mm_n_q, mm_n_d;

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    n_d        = n_q;
    acc_d      = acc_q;
    sqr_pend_d = sqr_pend_q;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          base_d     = base;
          exp_d      = exp;
          n_d        = n;
          // Anything mod 1 is 0, including x^0.
          acc_d      = (n == WIDTH'(1)) ? '0 : WIDTH'(1);
          sqr_pend_d = 1'b0;
          state_d    = StCheck;
        end
      end
      StCheck: begin
        if (n_q == '0) begin
          acc_d   = '0;
          state_d = StFinish;
        end else if (exp_q == '0) begin
          state_d = StFinish;
        end else if (exp_q[0]) begin
          state_d = StMulReq;
        end else begin
          state_d = StSqrReq;
        end
      end
      StMulReq: state_d = StMulWait;
      StMulWait: begin
        if (mm_done) begin
          acc_d = mm_result;
          // On the top exponent bit the trailing square is useless; skip it.
          if ((exp_q >> 1) == '0) begin
            exp_d = '0;
          end else begin
            sqr_pend_d = 1'b1;
          end
          state_d = StGap;
        end
      end
      StSqrReq: state_d = StSqrWait;
      StSqrWait: begin
        if (mm_done) begin
          base_d  = mm_result;
          exp_d   = exp_q >> 1;
          state_d = StGap;
        end
      end
      // One dead cycle so the multiplier can recover after done.
      StGap: begin
        if (sqr_pend_q) begin
          sqr_pend_d = 1'b0;
          state_d    = StSqrReq;
        end else begin
          state_d = StCheck;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    mm_go_d  = (state_d == StMulReq) || (state_d == StSqrReq);
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    mm_n_d   = mm_n_q;
    done_d   = (state_d == StFinish);
    result_d = (state_d == StFinish) ? acc_d : result_q;
    busy_d   = (state_d != StIdle);
    if (state_d == StMulReq) begin
      mm_a_d = base_d;
      mm_b_d = acc_d;
      mm_n_d = n_d;
    end else if (state_d == StSqrReq) begin
      mm_a_d = base_d;
      mm_b_d = base_d;
      mm_n_d = n_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      exp_q      <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      sqr_pend_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_go_q    <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_n_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      sqr_pend_q <= sqr_pend_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mm_go_q    <= mm_go_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_n_q     <= mm_n_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign mm_go  = mm_go_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_n   = mm_n_q;

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Computes result = (base ^ exp) mod n using right-to-left binary square-and-multiply.
- It is the requesting side of the modular-multiplier go/done handshake. It issues each product as a one-cycle mm_go pulse to an external modmult instance and waits for mm_done.
- Sits between the RSA top-level (encrypt/decrypt key operation) and one shared modmult of equal WIDTH.

Parameters:
- WIDTH, 32, bit width of base, exp, n, result and all multiplier operands.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- go  input  1  start request; sampled only in IDLE.
- base  input  WIDTH  message/ciphertext operand; captured on accepted go.
- exp  input  WIDTH  exponent; captured on accepted go.
- n  input  WIDTH  modulus; captured on accepted go.
- result  output  WIDTH  final value; valid from the done cycle until the next accepted go.
- done  output  1  one-cycle pulse when result is valid.
- busy  output  1  high from the cycle after an accepted go through the done cycle.
- mm_go  output  1  one-cycle request pulse to the multiplier.
- mm_a  output  WIDTH  multiplier operand a.
- mm_b  output  WIDTH  multiplier operand b.
- mm_n  output  WIDTH  multiplier modulus.
- mm_result  input  WIDTH  multiplier product; valid when mm_done=1.
- mm_done  input  1  multiplier completion pulse.

Behaviour:
- Reset: all outputs are 0, state is IDLE, all internal registers are 0. Reset mid-operation aborts immediately. No mm_go is issued after reset deasserts until a new go is accepted.
- All outputs are registered.
- Registers: base_r, exp_r, n_r, acc_r, state.
- IDLE: on go, capture base_r=base, exp_r=exp, n_r=n, acc_r = (n==1) ? 0 : 1, then go to CHECK. go is ignored in every other state.
- CHECK:
  - If n_r==0: acc_r=0, go to FINISH; no multiplier request is issued.
  - Else if exp_r==0: go to FINISH.
  - Else if exp_r[0]==1: go to MUL_REQ.
  - Else: go to SQR_REQ.
- MUL_REQ: mm_go=1 for exactly this cycle, with mm_a=base_r, mm_b=acc_r, mm_n=n_r. Go to MUL_WAIT.
- MUL_WAIT:
  - mm_a, mm_b and mm_n are held stable until mm_done.
  - On mm_done: acc_r=mm_result.
  - Then, if (exp_r>>1)==0: exp_r=0 and go to GAP (the final square is skipped).
  - Otherwise go to GAP with a pending-square flag set.
- SQR_REQ: mm_go=1 for exactly this cycle, with mm_a=mm_b=base_r, mm_n=n_r. Go to SQR_WAIT.
- SQR_WAIT: on mm_done, base_r=mm_result and exp_r=exp_r>>1, then go to GAP.
- GAP: exactly one idle cycle, because the multiplier needs one recovery cycle after done before it can accept go.
  - If the pending-square flag is set: clear it and go to SQR_REQ.
  - Otherwise go to CHECK.
- FINISH: result=acc_r and done=1 for exactly one cycle, then go to IDLE. busy drops in the cycle after done.
- Operand handling:
  - base ≥ n is legal; the multiplier reduces operand a.
  - After the first square, base_r < n.
  - mm_go is never asserted in two consecutive cycles.
  - mm_go is never asserted while a request is outstanding.
- mm_done in any state other than MUL_WAIT/SQR_WAIT is ignored.
- Request count per operation: popcount(exp) MUL requests plus (bit-length(exp) − 1) SQR requests.
- No timeout: if mm_done never arrives, the block waits indefinitely; only rst recovers it.

Test Plan:
- base=4, exp=13, n=497, bench modmult attached → result=445, done pulses once, exactly 6 mm_go pulses (3 MUL, 3 SQR), each pulse one cycle wide.
- base=2, exp=10, n=1000 → result=24; 2 MUL plus 3 SQR requests; mm_go is never asserted in the cycle immediately following mm_done.
- exp=0, n=7, base=5 → result=1, zero mm_go pulses; n=1, exp=5, base=3 → result=0.
- n=0, base=9, exp=3 → result=0, done asserted, zero mm_go pulses.
- Back-to-back ops: go held high continuously → second operation starts only from IDLE after done; go pulses during busy are ignored; both results are correct (e.g. 4^13 mod 497=445, then 7^3 mod 11=2).
- Assert rst while in SQR_WAIT of 4^13 mod 497 → outputs 0 in the same cycle; after release no mm_go until a new go; a fresh 4^13 mod 497 returns 445.
